stream_mux_2to1_rr: RTL
=======================

Name: stream_mux_2to1_rr

Overview:
- Registered 2-input stream multiplexer with round-robin arbitration.
- Sits directly upstream of the plain combinational 2:1 select path and generates the `sel` decision that path previously took from outside.
- Each input carries valid/ready/data/last; the output is one valid/ready stream tagged with the source index.
- Provides fair sharing of one downstream consumer between two producers, with one register stage breaking the timing path.

Parameters:
- DATA_W, 8, width of each data beat.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in0_valid  in  1  source 0 beat valid.
- in0_ready  out  1  source 0 beat accepted this cycle.
- in0_data  in  DATA_W  source 0 data.
- in0_last  in  1  source 0 end-of-packet marker.
- in1_valid  in  1  source 1 beat valid.
- in1_ready  out  1  source 1 beat accepted this cycle.
- in1_data  in  DATA_W  source 1 data.
- in1_last  in  1  source 1 end-of-packet marker.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts output beat.
- out_data  out  DATA_W  selected data.
- out_last  out  1  selected last marker.
- out_sel  out  1  source index of the current output beat (0 or 1).

Behaviour:
- Reset (async assert, sync-safe release):
  - out_valid=0, out_data=0, out_last=0, out_sel=0.
  - Priority pointer favours source 0.
  - Lock cleared.
  - Any in-flight beat is dropped.
- Output register: single entry.
  - load_en = !out_valid || out_ready.
- Grant (combinational):
  - Only one input valid: grant that input.
  - Both valid: grant the input the pointer favours.
  - Neither valid: no grant.
- inX_ready = load_en && (grant==X).
  - At most one ready is high per cycle.
  - inX_ready never depends on inX_valid of the same source beyond grant selection.
- Transfer on inX_valid && inX_ready:
  - Next cycle: out_valid=1, out_data=inX_data, out_last=inX_last, out_sel=X.
  - Latency: input handshake to out_valid is 1 cycle.
- Drain without new load: out_valid && out_ready && no grant -> out_valid=0 next cycle. out_data, out_last and out_sel hold their last values.
- Simultaneous drain and load in the same cycle: the new beat replaces the old one, giving full throughput of 1 beat/cycle.
- Stall: out_valid && !out_ready -> out_data, out_last and out_sel stable; both in_ready=0.
- Pointer update: after each accepted beat from X, the pointer favours the other source.
- Fairness requirement: with both inputs continuously valid and out_ready=1, out_sel alternates 0,1,0,1.
- No combinational path from any in*_valid/data to out_valid/out_data.
- A combinational path out_ready -> in*_ready is permitted.

Optional Feature:
- Macro: MUX_PKT_LOCK_EN.
- Defined (packet lock):
  - Once a beat with last=0 is accepted from X, grant locks to X until a beat with last=1 from X is accepted.
  - The pointer updates only on a last=1 beat.
  - While locked, the other source's ready stays 0 even if X is not valid.
  - Reset clears the lock.
- Undefined:
  - Arbitration is per beat as above.
  - in*_last is forwarded to out_last only; it does not affect grant or pointer.

Decomposition:
- Package mux_pkg:
  - DATA_W default constant.
  - Source-index constants SRC0=1'b0, SRC1=1'b1.
- Sub-module rr_arb2:
  - Inputs: req[1:0], advance, last.
  - Outputs: one-hot grant and grant index.
  - Holds the pointer and, under MUX_PKT_LOCK_EN, the lock flag.
- Top level holds the output register and the handshake logic.

Test Plan:
- Reset mid-stream: rst_n low while out_valid=1 -> out_valid=0, out_sel=0, out_data=0 immediately, without waiting for clk; first grant after release goes to src0 when both valid.
- Single source: in0_valid=1, data 0xA5, out_ready=1 -> one cycle later out_valid=1, out_data=0xA5, out_sel=0; in1_ready stays 0.
- Contention: both valid every cycle, data0=0x11, data1=0x22, out_ready=1 -> out_sel sequence 0,1,0,1 and out_data 0x11,0x22,0x11,0x22, one beat per cycle.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> out_data, out_last, out_sel constant and in0_ready=in1_ready=0; out_ready=1 -> next beat loads the same cycle the held beat drains.
- Drain to empty: last input beat accepted, then inputs idle with out_ready=1 -> out_valid falls after one cycle; no spurious readies.
- MUX_PKT_LOCK_EN: src0 sends 3 beats with last=0,0,1 while src1 is valid throughout -> out_sel=0,0,0 then 1; with the macro undefined, the same stimulus gives 0,1,0,1.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared constants for the round-robin 2:1 stream multiplexer and its arbiter.
// Optional build macro recognised by the slice: MUX_PKT_LOCK_EN (packet lock).
package mux_pkg;

  localparam int DEF_DATA_W = 8;

  localparam logic SRC0 = 1'b0;
  localparam logic SRC1 = 1'b1;

  function automatic logic [1:0] idx_to_onehot(input logic idx);
    return {idx, ~idx};
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter with a registered priority pointer.
// With MUX_PKT_LOCK_EN defined, a grant sticks to one source until it sends last.
module rr_arb2
  import mux_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  input  logic       last,
  output logic [1:0] grant,
  output logic       grant_idx
);

  // ptr names the source that wins when both request
  logic ptr;
  logic arb_idx;
  logic arb_any;
  logic grant_any;

  always_comb begin
    arb_idx = SRC0;
    arb_any = 1'b0;
    if (req == 2'b11) begin
      arb_idx = ptr;
      arb_any = 1'b1;
    end else if (req[1]) begin
      arb_idx = SRC1;
      arb_any = 1'b1;
    end else if (req[0]) begin
      arb_idx = SRC0;
      arb_any = 1'b1;
    end
  end

`ifdef MUX_PKT_LOCK_EN
  logic lock;
  logic lock_src;

  // A held packet keeps its grant even while its source idles, so the other
  // source can never interleave beats into it.
  always_comb begin
    grant_idx = lock ? lock_src : arb_idx;
    grant_any = lock | arb_any;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= SRC0;
      lock     <= 1'b0;
      lock_src <= SRC0;
    end else if (advance) begin
      lock     <= !last;
      lock_src <= grant_idx;
      if (last) begin
        ptr <= ~grant_idx;
      end
    end
  end
`else
  logic unused_last;
  assign unused_last = last;

  always_comb begin
    grant_idx = arb_idx;
    grant_any = arb_any;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= SRC0;
    end else if (advance) begin
      ptr <= ~grant_idx;
    end
  end
`endif

  assign grant = grant_any ? idx_to_onehot(grant_idx) : 2'b00;

endmodule

// File: rtl/stream_mux_2to1_rr.sv
// Registered 2:1 stream mux: round-robin arbiter plus a single-entry output register.
// Build macro MUX_PKT_LOCK_EN switches the arbiter to whole-packet grants.
module stream_mux_2to1_rr
  import mux_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in0_valid,
  output logic              in0_ready,
  input  logic [DATA_W-1:0] in0_data,
  input  logic              in0_last,
  input  logic              in1_valid,
  output logic              in1_ready,
  input  logic [DATA_W-1:0] in1_data,
  input  logic              in1_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              out_sel
);

  // Handshake: a beat moves on any edge where valid && ready; a producer keeps
  // valid and payload stable until it does, and ready never waits on valid of
  // its own stream except through grant selection.
  logic [1:0]        grant;
  logic              grant_idx;
  logic              load_en;
  logic              xfer;
  logic [DATA_W-1:0] sel_data;
  logic              sel_last;

  rr_arb2 u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       ({in1_valid, in0_valid}),
    .advance   (xfer),
    .last      (sel_last),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign load_en   = !out_valid || out_ready;
  assign in0_ready = load_en && grant[0];
  assign in1_ready = load_en && grant[1];
  assign xfer      = (in0_valid && in0_ready) || (in1_valid && in1_ready);

  assign sel_data = (grant_idx == SRC1) ? in1_data : in0_data;
  assign sel_last = (grant_idx == SRC1) ? in1_last : in0_last;

  // Payload holds after a drain so downstream debug sees the last beat sent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_sel   <= SRC0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_last  <= sel_last;
      out_sel   <= grant_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
